// File: rtl/axis_nibble_unpacker_pkg.sv
// Shared types and helpers for the AXI-Stream nibble unpacker.
//   unpack_state_t : control FSM states
//   NIBBLE_W       : bits per nibble
//   WORD_NIBBLES   : nibbles carried by one full input word
//   nib2keep()     : nibble count -> valid bit count carried on tkeep
//   clamp_chunk()  : config field -> legal chunk size (1..4)
package axis_unpack_pkg;

    localparam int NIBBLE_W     = 4;
    localparam int STREAM_WIDTH = 16;
    localparam int WORD_NIBBLES = STREAM_WIDTH / NIBBLE_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_CONFIG,
        STREAM,
        FLUSH
    } unpack_state_t;

    // tkeep carries a bit count, not a byte mask: 4 bits per valid nibble.
    function automatic logic [7:0] nib2keep(input logic [2:0] n);
        return {3'b000, n, 2'b00};
    endfunction

    // Zero and out-of-range sizes fall back to a full word per beat.
    function automatic logic [2:0] clamp_chunk(input logic [2:0] cfg);
        if (cfg == 3'd0 || cfg > 3'd4)
            return 3'd4;
        return cfg;
    endfunction

endpackage

// File: rtl/axis_nibble_unpacker_if.sv
// Generic AXI-Stream bundle used for the config, input and output channels.
//   tdata/tkeep/tlast/tvalid : driven by the master
//   tready                   : driven by the slave
// Channels that have no use for tkeep or tlast simply leave them unused.
interface axis_nibble_unpacker_if #(
    parameter int DATA_W = 16,
    parameter int KEEP_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tkeep, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_nibble_unpacker_buf.sv
// nibble_shift_buf: nibble FIFO built as a shift register.
//   clk, aresetn : clock, synchronous active-low reset
//   push         : append the four nibbles of push_word (MSB nibble first)
//   push_word    : word to append
//   pop_n        : number of oldest nibbles removed this cycle (0..4)
//   count        : nibbles currently held
//   head_word    : four oldest nibbles, oldest in [15:12]
// Push and pop act on the logical sequence {contents, pushed word}, so a pop
// may reach into the word being pushed in the same cycle.
module nibble_shift_buf
    import axis_unpack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    push,
    input  logic [STREAM_WIDTH-1:0] push_word,
    input  logic [2:0]              pop_n,
    output logic [CW-1:0]           count,
    output logic [STREAM_WIDTH-1:0] head_word
);
    localparam int SW = CW + 1;
    localparam int IW = $clog2(DEPTH);

    logic [NIBBLE_W-1:0] buf_reg  [DEPTH];
    logic [NIBBLE_W-1:0] buf_next [DEPTH];
    logic [NIBBLE_W-1:0] word_nib [WORD_NIBBLES];
    logic [CW-1:0]       count_reg;
    logic [SW-1:0]       count_sum;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_NIBBLES; gi++) begin : g_word
            assign word_nib[gi] = push_word[STREAM_WIDTH-1-NIBBLE_W*gi -: NIBBLE_W];
            assign head_word[STREAM_WIDTH-1-NIBBLE_W*gi -: NIBBLE_W] = buf_reg[gi];
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [SW-1:0] src;
            logic [SW-1:0] rel;

            // Slot gi takes element gi+pop_n of the combined sequence.
            assign src = SW'(gi) + SW'(pop_n);
            assign rel = src - SW'(count_reg);

            always_comb begin
                buf_next[gi] = '0;
                if (src < SW'(count_reg))
                    buf_next[gi] = buf_reg[src[IW-1:0]];
                else if (push && rel < SW'(WORD_NIBBLES))
                    buf_next[gi] = word_nib[rel[1:0]];
            end

            always_ff @(posedge clk) begin
                if (!aresetn)
                    buf_reg[gi] <= '0;
                else
                    buf_reg[gi] <= buf_next[gi];
            end
        end
    endgenerate

    assign count_sum = SW'(count_reg) + (push ? SW'(WORD_NIBBLES) : SW'(0)) - SW'(pop_n);

    always_ff @(posedge clk) begin
        if (!aresetn)
            count_reg <= '0;
        else
            count_reg <= count_sum[CW-1:0];
    end

    assign count = count_reg;

endmodule

// File: rtl/axis_nibble_unpacker.sv
// axis_nibble_unpacker: splits 16-bit AXI-Stream words into beats of
// 1..4 nibbles, MSB nibble first, right-aligned with zeroed upper bits.
//   clk, aresetn : clock, synchronous active-low reset
//   config_in    : slave, tdata[2:0] = chunk size per packet
//   s_axis       : slave, full 16-bit words with tlast
//   m_axis       : master, beats with tkeep = valid bit count, tlast on tail
// Optional macro UNPACK_STATS_EN adds stat_pkt_count / stat_beat_count.
module axis_nibble_unpacker
    import axis_unpack_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BUF_NIBBLES = 8
) (
    input  logic clk,
    input  logic aresetn,
    axis_nibble_unpacker_if.slave  config_in,
    axis_nibble_unpacker_if.slave  s_axis,
    axis_nibble_unpacker_if.master m_axis
`ifdef UNPACK_STATS_EN
    ,
    output logic [15:0] stat_pkt_count,
    output logic [15:0] stat_beat_count
`endif
);
    localparam int CW = $clog2(BUF_NIBBLES + 1);

    generate
        if (DATA_WIDTH != STREAM_WIDTH) begin : g_bad_width
            $error("axis_nibble_unpacker: DATA_WIDTH must be 16");
        end
        if (BUF_NIBBLES < 2 * DATA_WIDTH / NIBBLE_W) begin : g_bad_depth
            $error("axis_nibble_unpacker: BUF_NIBBLES too small");
        end
    endgenerate

    unpack_state_t state_reg, state_next;
    logic [2:0]    chunk_reg, chunk_next;

    logic [CW-1:0] count;
    logic [15:0]   head_word;
    logic [3:0]    s_nib [WORD_NIBBLES];
    logic [3:0]    win   [WORD_NIBBLES];

    logic        can_load, emit_buf, avail, emit, s_ready, s_hs, m_hs, beat_last;
    logic [2:0]  take_n;
    logic [15:0] beat;

    logic [15:0] m_tdata_reg;
    logic [7:0]  m_tkeep_reg;
    logic        m_tlast_reg, m_tvalid_reg;

    logic unused_ok;
    assign unused_ok = ^{config_in.tdata[7:3], config_in.tkeep, config_in.tlast, s_axis.tkeep};

    nibble_shift_buf #(.DEPTH(BUF_NIBBLES)) u_buf (
        .clk       (clk),
        .aresetn   (aresetn),
        .push      (s_hs),
        .push_word (s_axis.tdata),
        .pop_n     (emit ? take_n : 3'd0),
        .count     (count),
        .head_word (head_word)
    );

    // Emit window: buffered nibbles first, then the incoming word. This lets a
    // word accepted this cycle feed the output register directly.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_NIBBLES; gi++) begin : g_win
            assign s_nib[gi] = s_axis.tdata[15-4*gi -: 4];
            assign win[gi]   = (CW'(gi) < count) ? head_word[15-4*gi -: 4]
                                                 : s_nib[2'(CW'(gi) - count)];
        end
    endgenerate

    assign can_load = !m_tvalid_reg || m_axis.tready;
    assign emit_buf = can_load && (count >= CW'(chunk_reg));
    assign m_hs     = m_tvalid_reg && m_axis.tready;

    // Depends only on registered state and m_axis.tready. When the buffer
    // alone cannot emit, count < chunk <= 4 so a word always fits.
    always_comb begin
        s_ready = 1'b0;
        if (state_reg == STREAM)
            s_ready = (int'(count) + WORD_NIBBLES
                       - (emit_buf ? int'(chunk_reg) : 0)) <= BUF_NIBBLES;
    end

    assign s_hs = s_ready && s_axis.tvalid;

    always_comb begin
        avail     = 1'b0;
        take_n    = chunk_reg;
        beat_last = 1'b0;
        case (state_reg)
            STREAM: begin
                avail     = (count >= CW'(chunk_reg)) || s_hs;
                // Only a 4-nibble chunk from an empty buffer can consume the
                // whole tlast word in one beat.
                beat_last = s_hs && s_axis.tlast
                            && (int'(count) + WORD_NIBBLES == int'(chunk_reg));
            end
            FLUSH: begin
                avail     = (count != '0);
                beat_last = (count <= CW'(chunk_reg));
                if (count < CW'(chunk_reg))
                    take_n = 3'(count);
            end
            default: ;
        endcase
    end

    assign emit = can_load && avail;

    always_comb begin
        beat = '0;
        case (take_n)
            3'd1:    beat[3:0]  = win[0];
            3'd2:    beat[7:0]  = {win[0], win[1]};
            3'd3:    beat[11:0] = {win[0], win[1], win[2]};
            default: beat       = {win[0], win[1], win[2], win[3]};
        endcase
    end

    always_comb begin
        state_next = state_reg;
        chunk_next = chunk_reg;
        case (state_reg)
            IDLE:      state_next = RD_CONFIG;
            RD_CONFIG: if (config_in.tvalid) begin
                chunk_next = clamp_chunk(config_in.tdata[2:0]);
                state_next = STREAM;
            end
            STREAM:    if (s_hs && s_axis.tlast) state_next = FLUSH;
            FLUSH:     if (m_hs && m_tlast_reg)  state_next = RD_CONFIG;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_reg <= IDLE;
            chunk_reg <= 3'd4;
        end else begin
            state_reg <= state_next;
            chunk_reg <= chunk_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            m_tvalid_reg <= 1'b0;
            m_tlast_reg  <= 1'b0;
            m_tdata_reg  <= '0;
            m_tkeep_reg  <= '0;
        end else if (emit) begin
            m_tvalid_reg <= 1'b1;
            m_tlast_reg  <= beat_last;
            m_tdata_reg  <= beat;
            m_tkeep_reg  <= nib2keep(take_n);
        end else if (m_axis.tready) begin
            m_tvalid_reg <= 1'b0;
        end
    end

`ifdef UNPACK_STATS_EN
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            stat_pkt_count  <= '0;
            stat_beat_count <= '0;
        end else if (m_hs) begin
            stat_beat_count <= stat_beat_count + 16'd1;
            if (m_tlast_reg)
                stat_pkt_count <= stat_pkt_count + 16'd1;
        end
    end
`endif

    assign m_axis.tvalid    = m_tvalid_reg;
    assign m_axis.tlast     = m_tlast_reg;
    assign m_axis.tdata     = m_tdata_reg;
    assign m_axis.tkeep     = m_tkeep_reg;
    assign s_axis.tready    = s_ready;
    assign config_in.tready = (state_reg == RD_CONFIG);

endmodule

// File: tb/tb_axis_nibble_unpacker.sv
// Self-checking bench for axis_nibble_unpacker. Expected beats come from a
// nibble-queue model: flatten each packet into nibbles, cut into chunk-sized
// groups, and mark the final (possibly short) group with tlast.
module tb_axis_nibble_unpacker;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    axis_nibble_unpacker_if #(.DATA_W(8),  .KEEP_W(1)) cfg_if ();
    axis_nibble_unpacker_if #(.DATA_W(16), .KEEP_W(1)) s_if ();
    axis_nibble_unpacker_if #(.DATA_W(16), .KEEP_W(8)) m_if ();

`ifdef UNPACK_STATS_EN
    logic [15:0] stat_pkt_count, stat_beat_count;
`endif

    axis_nibble_unpacker dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .config_in (cfg_if),
        .s_axis    (s_if),
        .m_axis    (m_if)
`ifdef UNPACK_STATS_EN
        ,
        .stat_pkt_count  (stat_pkt_count),
        .stat_beat_count (stat_beat_count)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int pkts_done   = 0;
    int beats_done  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_chunk(input logic [7:0] cfg);
        int c;
        c = int'(cfg[2:0]);
        return (c == 0 || c > 4) ? 4 : c;
    endfunction

    // Reference model: nibble list -> chunked beats.
    function automatic void build_expected(input int chunk, input logic [15:0] words[$],
                                           output beat_t q[$]);
        logic [3:0] nibs[$];
        beat_t      b;
        int         n;
        q = {};
        foreach (words[w])
            for (int k = 0; k < 4; k++)
                nibs.push_back(4'((words[w] >> (12 - 4 * k)) & 16'hF));
        while (nibs.size() > 0) begin
            n = (nibs.size() < chunk) ? nibs.size() : chunk;
            b.data = '0;
            for (int i = 0; i < n; i++)
                b.data = (b.data << 4) | 16'(nibs.pop_front());
            b.keep = 8'(4 * n);
            b.last = (nibs.size() == 0);
            q.push_back(b);
        end
    endfunction

    task automatic do_config(input logic [7:0] cfg);
        bit ok;
        ok = 1'b0;
        cfg_if.tdata  = cfg;
        cfg_if.tvalid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (cfg_if.tready) ok = 1'b1;
            @(posedge clk); #1;
        end
        cfg_if.tvalid = 1'b0;
        cfg_if.tdata  = 8'($urandom);
        check("cfg_handshake", 32'(ok), 32'd1);
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall after 2 beats
    task automatic stream_packet(input logic [7:0] cfg, input logic [15:0] words[$],
                                 input int mode, input int gap_pct, input bit perf);
        beat_t exp_q[$];
        beat_t e;
        int    nwords, wi, beats, stall_cnt;
        int    first_acc, first_val, last_hs;
        bit    done, acc_now, last_acc, last_chk, saw_drop, hold;
        logic [25:0] held;

        do_config(cfg);
        build_expected(eff_chunk(cfg), words, exp_q);
        nwords = words.size();
        wi = 0; beats = 0; stall_cnt = 0;
        first_acc = -1; first_val = -1; last_hs = -1;
        done = 0; last_acc = 0; last_chk = 0; saw_drop = 0; hold = 0;
        held = '0;

        for (int t = 0; t < 400 && !done; t++) begin
            s_if.tvalid = (wi < nwords) && ($urandom_range(99) >= gap_pct);
            s_if.tdata  = (wi < nwords) ? words[wi] : 16'($urandom);
            s_if.tlast  = (wi == nwords - 1);
            case (mode)
                0: m_if.tready = 1'b1;
                1: m_if.tready = 1'($urandom_range(1));
                default: begin
                    if (beats == 2 && stall_cnt < 5) begin
                        m_if.tready = 1'b0;
                        stall_cnt++;
                    end else
                        m_if.tready = 1'b1;
                end
            endcase

            @(negedge clk);
            acc_now = 0;
            if (last_acc && !last_chk) begin
                check("s_tready_after_last", 32'(s_if.tready), 32'd0);
                last_chk = 1;
            end
            if (hold)
                check("hold_stable", 32'({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata}), 32'(held));
            if (wi < nwords && !s_if.tready) saw_drop = 1;
            if (s_if.tvalid && s_if.tready) begin
                acc_now = 1;
                if (first_acc < 0) first_acc = cyc;
            end
            if (m_if.tvalid && first_val < 0) first_val = cyc;
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                    done = 1;
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", 32'(m_if.tdata), 32'(e.data));
                    check("tkeep", 32'(m_if.tkeep), 32'(e.keep));
                    check("tlast", 32'(m_if.tlast), 32'(e.last));
                    beats++;
                    beats_done++;
                    last_hs = cyc;
                    if (e.last) done = 1;
                end
            end
            hold = m_if.tvalid && !m_if.tready;
            held = {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata};

            @(posedge clk); #1;
            if (acc_now) begin
                if (wi == nwords - 1) last_acc = 1;
                wi++;
            end
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;

        check("packet_complete", 32'(done), 32'd1);
        check("first_beat_latency", 32'(first_val - first_acc), 32'd1);
        if (perf) begin
            check("s_tready_never_dropped", 32'(saw_drop), 32'd0);
            check("back_to_back_beats", 32'(last_hs - first_val), 32'(nwords - 1));
        end
        if (mode == 2)
            check("input_stalled", 32'(saw_drop), 32'd1);

        @(negedge clk);
        check("cfg_ready_after_pkt", 32'(cfg_if.tready), 32'd1);
        check("m_idle_after_pkt", 32'(m_if.tvalid), 32'd0);
        pkts_done++;
`ifdef UNPACK_STATS_EN
        check("stat_pkt_count", 32'(stat_pkt_count), 32'(pkts_done));
        check("stat_beat_count", 32'(stat_beat_count), 32'(beats_done));
`endif
        @(posedge clk); #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
        check({tag, "_m_tlast"},  32'(m_if.tlast),  32'd0);
        check({tag, "_m_tdata"},  32'(m_if.tdata),  32'd0);
        check({tag, "_m_tkeep"},  32'(m_if.tkeep),  32'd0);
        check({tag, "_s_tready"}, 32'(s_if.tready), 32'd0);
        check({tag, "_cfg_tready"}, 32'(cfg_if.tready), 32'd0);
    endtask

    initial begin
        logic [15:0] words[$];

        cfg_if.tdata = '0; cfg_if.tvalid = 1'b0; cfg_if.tkeep = '0; cfg_if.tlast = 1'b0;
        s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tkeep = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;

        // Reset state
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        aresetn = 1'b1;

        // chunk=1, single word 0xABCD
        words = {16'hABCD};
        stream_packet(8'd1, words, 0, 0, 1'b0);

        // chunk=3, 0x1234 0x5678
        words = {16'h1234, 16'h5678};
        stream_packet(8'd3, words, 0, 0, 1'b0);

        // chunk=4, 8 words back-to-back
        words = {};
        for (int i = 0; i < 8; i++) words.push_back(16'($urandom));
        stream_packet(8'd4, words, 0, 0, 1'b1);

        // config 0x00 and 0x07 both clamp to 4
        words = {};
        for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
        stream_packet(8'h00, words, 1, 0, 1'b0);
        words = {};
        for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
        stream_packet(8'h07, words, 1, 0, 1'b0);

        // chunk=2 with a 5-cycle downstream stall
        words = {};
        for (int i = 0; i < 6; i++) words.push_back(16'($urandom));
        stream_packet(8'd2, words, 2, 0, 1'b0);

        // Mid-packet reset: leave a pending beat and buffered nibbles behind
        do_config(8'd2);
        m_if.tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 16'($urandom);
            s_if.tlast  = 1'b0;
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        m_if.tready = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        @(negedge clk);
        check("midreset_rd_config", 32'(cfg_if.tready), 32'd1);
        @(posedge clk); #1;
        pkts_done  = 0;
        beats_done = 0;

        // Randomized packets with random config, gaps and backpressure
        for (int p = 0; p < 8; p++) begin
            words = {};
            for (int i = 0; i < int'($urandom_range(6, 1)); i++)
                words.push_back(16'($urandom));
            stream_packet(8'($urandom), words, 1, 30, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_nibble_unpacker.md
Name: axis_nibble_unpacker

Overview:
Upstream neighbour of the nibble packer. Takes full 16-bit AXI-Stream words and re-emits them as beats of a configured nibble count (1..4), MSB nibble first, right-aligned.
Output tkeep carries the valid *bit* count (4/8/12/16), the same encoding the packer consumes. The pair can be chained packer<-unpacker for loopback test.
Packets never mix. The tail of a packet is flushed as a partial beat with tlast.

Parameters:
DATA_WIDTH, 16, stream data width; must be 16 (4 nibbles). Elaboration error otherwise.
BUF_NIBBLES, 8, nibble buffer depth; must be >= 2*DATA_WIDTH/4.

Ports:
clk  in  1  clock, all logic on rising edge
aresetn  in  1  synchronous active-low reset
config_in_tdata  in  8  bits[2:0] = chunk size in nibbles; bits[7:3] ignored
config_in_tvalid  in  1  config valid
config_in_tready  out  1  high only in RD_CONFIG
s_axis_tdata  in  16  input word; all 4 nibbles valid
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last word of packet
m_axis_tdata  out  16  output beat, right-aligned, unused upper bits zero
m_axis_tvalid  out  1  output valid (registered)
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of packet
m_axis_tkeep  out  8  valid bit count: 4, 8, 12 or 16

Behaviour:
- Reset: clk with aresetn==0 -> state=IDLE, buffer count=0, chunk=4. All outputs 0: m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, s_axis_tready, config_in_tready.
- Reset mid-packet discards buffer contents and any pending output beat. Reset has priority over all other events.
- FSM states:
  - IDLE: go to RD_CONFIG next cycle.
  - RD_CONFIG: config_in_tready=1. On config handshake, latch chunk (0 or >4 clamps to 4) and go to STREAM.
  - STREAM: accept words, emit chunk-sized beats. After accepting the tlast word, go to FLUSH.
  - FLUSH: s_axis_tready=0. Drain the buffer in chunk-sized beats. The final beat carries the remaining count r (1<=r<=chunk), tkeep=4*r and tlast=1. When that beat handshakes, go to RD_CONFIG; a new config is required per packet.
- Buffer: nibble shift buffer with count 0..BUF_NIBBLES.
  - An accepted word appends 4 nibbles behind existing contents; s_axis_tdata[15:12] is emitted first.
  - Emit takes the oldest chunk nibbles.
- s_axis_tready (STREAM only) = (count - (emitting ? chunk : 0) + 4) <= BUF_NIBBLES. Emitting means the output register is loaded this cycle. Combinational from registered state and m_axis_tready; no dependence on s_axis_tvalid.
- Output register: loads when (!m_axis_tvalid || m_axis_tready), provided the buffer holds >= chunk nibbles, or we are in FLUSH with count>0.
  - Holds tdata, tkeep, tlast stable while tvalid && !tready.
  - tvalid drops after handshake if nothing is loadable.
- Latency: word accepted in cycle N -> first beat valid in N+1.
- Throughput: chunk=4 sustains 1 word/cycle in, 1 beat/cycle out. In general, input stalls to match output rate.
- Simultaneous accept and emit in the same cycle: count_next = count + 4 - chunk.
- Single-word packet with tlast: STREAM -> FLUSH on accept, normal drain.
- Config handshake outside RD_CONFIG: impossible (tready=0). config_in_tdata is ignored there.

Optional Feature:
UNPACK_STATS_EN.
- Defined: adds output ports stat_pkt_count[15:0] and stat_beat_count[15:0].
  - stat_pkt_count increments on each m_axis handshake with tlast.
  - stat_beat_count increments on each m_axis handshake.
  - Both wrap at 16 bits and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package axis_unpack_pkg holds:
  - state enum IDLE/RD_CONFIG/STREAM/FLUSH;
  - NIBBLE_W=4;
  - WORD_NIBBLES=DATA_WIDTH/4;
  - function nib2keep(n) returning 4*n as 8 bits;
  - function clamp_chunk(cfg).
- One sub-module, nibble_shift_buf: append-4/pop-k buffer with count output. It holds the buffer storage and count and does no handshaking.

Test Plan:
- chunk=1, one word 0xABCD tlast, tready=1 -> beats 0x000A,0x000B,0x000C,0x000D, tkeep=4 each, tlast only on 0x000D; s_axis_tready=0 after accept.
- chunk=3, words 0x1234,0x5678(tlast) -> beats 0x0123(tkeep 12), 0x0456(12), 0x0078(tkeep 8, tlast); then config_in_tready=1.
- chunk=4, 8-word packet, tready=1 -> 8 beats equal to the inputs in back-to-back cycles; s_axis_tready never drops; first beat 1 cycle after first accept.
- config_in_tdata=0x00 then 0x07 -> both behave as chunk=4 (tkeep=16).
- chunk=2, m_axis_tready held 0 for 5 cycles mid-packet -> tdata/tkeep/tlast stable, no loss or duplication; input stalls once buffer count reaches 6+.
- aresetn=0 for 1 cycle mid-packet -> next cycle all outputs 0; IDLE then RD_CONFIG; old nibbles never appear.
